// File: rtl/membus_sensor_regfile_if.sv
// rtl/membus_sensor_regfile_if.sv - memory-bus request/response bundle between bridge and register bank
interface membus_sensor_regfile_if;
    logic       read_req;
    logic       write_req;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;

    modport master (output read_req, write_req, addr, wdata, input rdata);
    modport slave  (input read_req, write_req, addr, wdata, output rdata);
endinterface

// File: rtl/membus_sensor_regfile.sv
// rtl/membus_sensor_regfile.sv - sensor register bank with atomic 16-bit snapshot reads and data interrupt
module membus_sensor_regfile #(
    parameter logic [7:0] VER_ID   = 8'hA4,
    parameter logic [7:0] CTRL_RST = 8'h01
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    membus_sensor_regfile_if.slave         bus,
    input  logic [15:0]                    co2_value_i,
    input  logic                           co2_valid_i,
    input  logic [15:0]                    pm_value_i,
    input  logic                           pm_valid_i,
    output logic                           sensor_en_o,
    output logic                           irq_o
);
    logic [7:0]  ctrl;
    logic [7:0]  scratch;
    logic [7:0]  sample_cnt;
    logic [7:0]  co2_shadow;
    logic [7:0]  pm_shadow;
    logic [7:0]  rdata;
    logic [3:0]  status;
    logic [15:0] co2_hold;
    logic [15:0] pm_hold;
    logic        irq;

    logic        wr;
    logic        rd;
    logic        co2_acc;
    logic        pm_acc;
    logic        status_rd;
    logic [7:0]  ctrl_n;
    logic [7:0]  rd_mux;
    logic [3:0]  status_clr;
    logic [3:0]  status_n;

    // A write strobe always wins over a coincident read strobe.
    assign wr        = bus.write_req;
    assign rd        = bus.read_req & ~bus.write_req;
    assign co2_acc   = co2_valid_i & ctrl[0];
    assign pm_acc    = pm_valid_i & ctrl[0];
    assign status_rd = rd && (bus.addr == 7'h01);

    // Read data selection; HI bytes come from the shadow, never the live holding register.
    always_comb begin
        rd_mux = 8'h00;
        case (bus.addr)
            7'h00:   rd_mux = VER_ID;
            7'h01:   rd_mux = {4'h0, status};
            7'h02:   rd_mux = ctrl;
            7'h03:   rd_mux = scratch;
            7'h04:   rd_mux = co2_hold[7:0];
            7'h05:   rd_mux = co2_shadow;
            7'h06:   rd_mux = pm_hold[7:0];
            7'h07:   rd_mux = pm_shadow;
            7'h08:   rd_mux = sample_cnt;
            default: rd_mux = 8'h00;
        endcase
    end

    // Next-state for CTRL and STATUS: clear-on-read first, then sample events set on top.
    // Overrun is judged against the post-clear flag so a sample coinciding with the read is a fresh one.
    always_comb begin
        ctrl_n     = (wr && (bus.addr == 7'h02)) ? bus.wdata : ctrl;
        status_clr = status_rd ? 4'h0 : status;
        status_n   = status_clr;
        if (co2_acc) begin
            status_n[0] = 1'b1;
            status_n[2] = status_clr[2] | status_clr[0];
        end
        if (pm_acc) begin
            status_n[1] = 1'b1;
            status_n[3] = status_clr[3] | status_clr[1];
        end
    end

    // Register state, read data capture, sample capture and interrupt.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ctrl       <= CTRL_RST;
            scratch    <= 8'h00;
            sample_cnt <= 8'h00;
            co2_shadow <= 8'h00;
            pm_shadow  <= 8'h00;
            rdata      <= 8'h00;
            status     <= 4'h0;
            co2_hold   <= 16'h0000;
            pm_hold    <= 16'h0000;
            irq        <= 1'b0;
        end else begin
            ctrl   <= ctrl_n;
            status <= status_n;
            irq    <= ctrl_n[1] & (|status_n);
            if (wr && (bus.addr == 7'h03)) begin
                scratch <= bus.wdata;
            end
            if (rd) begin
                rdata <= rd_mux;
                if (bus.addr == 7'h04) begin
                    co2_shadow <= co2_hold[15:8];
                end
                if (bus.addr == 7'h06) begin
                    pm_shadow <= pm_hold[15:8];
                end
            end
            if (co2_acc) begin
                co2_hold   <= co2_value_i;
                sample_cnt <= sample_cnt + 8'd1;
            end
            if (pm_acc) begin
                pm_hold <= pm_value_i;
            end
        end
    end

    assign bus.rdata   = rdata;
    assign sensor_en_o = ctrl[0];
    assign irq_o       = irq;
endmodule
